// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one synchronous dmem port between the CPU and a DMA engine.
// Round-robin on contention, with a bounded DMA lock so the CPU is never starved.
module dmem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,

  input  logic              dma_req,
  input  logic [3:0]        dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,

  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    DMA
  } owner_t;

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  owner_t      owner;
  logic [7:0]  burst_cnt;
  logic        tag_valid;
  logic        tag_dma;
  logic        cpu_gnt;
  logic        lock_hold;

  assign lock_hold = (owner == DMA) && dma_lock && dma_req && (burst_cnt < BURST_LIMIT);

  // Grants are forced off while reset is held so nothing reaches the memory.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (rst) begin
      if (lock_hold) begin
        dma_gnt = 1'b1;
      end else if (cpu_req && dma_req) begin
        if (owner == CPU) begin
          dma_gnt = 1'b1;
        end else begin
          cpu_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign mem_en    = cpu_gnt | dma_gnt;

  always_comb begin
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we   = dma_we;
      mem_addr = dma_addr;
      mem_din  = dma_wdata;
    end
  end

  // burst_cnt only counts DMA beats taken while the CPU is actually waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= IDLE;
      burst_cnt <= 8'd0;
      tag_valid <= 1'b0;
      tag_dma   <= 1'b0;
    end else begin
      if (cpu_gnt) begin
        owner <= CPU;
      end else if (dma_gnt) begin
        owner <= DMA;
      end else begin
        owner <= IDLE;
      end
      burst_cnt <= (dma_gnt && cpu_req) ? burst_cnt + 8'd1 : 8'd0;
      tag_valid <= (cpu_gnt && (cpu_we == 4'b0000)) || (dma_gnt && (dma_we == 4'b0000));
      tag_dma   <= dma_gnt;
    end
  end

  assign cpu_rvalid = tag_valid & ~tag_dma;
  assign dma_rvalid = tag_valid &  tag_dma;
  assign cpu_rdata  = cpu_rvalid ? mem_dout : 32'd0;
  assign dma_rdata  = dma_rvalid ? mem_dout : 32'd0;

endmodule
